// File: rtl/caliptra_tlul_rsp_intg_monitor.sv
// -----------------------------------------------------------------------------
// caliptra_tlul_rsp_intg_monitor
//
// Purpose:
//   This module watches NumCh TL-UL D-channels in parallel and checks the
//   response integrity of each one. Every channel gets a SECDED check of the
//   response header against d_user.rsp_intg. When enabled, d_data is also
//   checked against d_user.data_intg. For each channel the monitor keeps a
//   saturating error counter and a sticky flag. It also records the first
//   channel that raised an error. A small state machine (OK / ERR / ALERT)
//   drives a registered threshold alert. All recorded state is cleared by the
//   host through clr_i.
//
// Handshake semantics:
//   A D-channel beat is accepted in a cycle where tl_i[i].d_valid and
//   d_ready_i[i] are both high. err_o flags a bad beat as soon as it is
//   valid, whatever d_ready_i is. Counters, sticky flags, the first-error
//   capture and the state machine change only on accepted bad beats. A bad
//   beat that stalls for several cycles is therefore counted once.
//
// Ports:
//   clk_i            clock
//   rst_ni           synchronous active-low reset
//   tl_i[NumCh]      monitored D-channels
//   d_ready_i        host d_ready per channel
//   clr_i            clears counters, sticky flags, first-error capture, alert
//   err_o            combinational per-channel integrity error (unlatched)
//   err_sticky_o     per-channel sticky error flag
//   err_cnt_o        packed counters, channel i at [i*CntW +: CntW]
//   first_err_vld_o  first_err_ch_o holds a valid capture
//   first_err_ch_o   index of the first erroring channel since reset/clear
//   state_o          FSM state: 0 OK, 1 ERR, 2 ALERT
//   alert_o          registered threshold alert
//
// Integrity code:
//   Both integrity fields use a 7-bit extended Hamming code. Bits [5:0] are
//   the XOR of the code positions of all set payload bits. The payload bits
//   occupy code positions 1, 2, 3, ... in order, skipping powers of two.
//   Bit [6] makes the overall parity of payload plus all check bits even.
//   The response payload is the 18-bit header
//   {d_opcode, d_param, d_size, d_source, d_sink, d_error}, zero-extended to
//   57 bits. The data payload is d_data, zero-extended to 57 bits.
// -----------------------------------------------------------------------------

package caliptra_tlul_rsp_intg_monitor_pkg;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        tl_d_user_t  d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Response header covered by rsp_intg, zero-extended to the 57-bit payload.
    function automatic logic [56:0] rsp_payload(input tl_d2h_t d);
        return {39'b0, d.d_opcode, d.d_param, d.d_size, d.d_source, d.d_sink, d.d_error};
    endfunction

    // Check bits for a 57-bit payload. Payload bit k sits at the k-th code
    // position that is not a power of two.
    function automatic logic [6:0] secded_chk(input logic [56:0] data);
        logic [5:0] syn;
        int         k;
        syn = '0;
        k   = 0;
        for (int p = 1; p < 64; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (data[6'(k)]) begin
                    syn = syn ^ 6'(p);
                end
                k++;
            end
        end
        return {(^data) ^ (^syn), syn};
    endfunction

    // Returns {double_err, single_err}. A single-bit error flips the overall
    // parity. Any nonzero syndrome with even parity is an uncorrectable error.
    function automatic logic [1:0] secded_dec(input logic [56:0] data, input logic [6:0] chk);
        logic [5:0] syn;
        logic       par;
        syn = secded_chk(data)[5:0] ^ chk[5:0];
        par = (^data) ^ (^chk);
        return {(syn != '0) & ~par, par};
    endfunction

endpackage

module caliptra_tlul_rsp_intg_monitor
    import caliptra_tlul_rsp_intg_monitor_pkg::*;
#(
    parameter int NumCh                  = 2,
    parameter bit EnableRspDataIntgCheck = 1'b0,
    parameter int CntW                   = 8,
    parameter int ErrThresh              = 1,
    parameter int ChW                    = (NumCh > 1) ? $clog2(NumCh) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  tl_d2h_t               tl_i [NumCh],
    input  logic [NumCh-1:0]      d_ready_i,
    input  logic                  clr_i,
    output logic [NumCh-1:0]      err_o,
    output logic [NumCh-1:0]      err_sticky_o,
    output logic [NumCh*CntW-1:0] err_cnt_o,
    output logic                  first_err_vld_o,
    output logic [ChW-1:0]        first_err_ch_o,
    output logic [1:0]            state_o,
    output logic                  alert_o
);

    localparam logic [1:0] StOk    = 2'd0;
    localparam logic [1:0] StErr   = 2'd1;
    localparam logic [1:0] StAlert = 2'd2;

    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] Thresh = CntW'(ErrThresh);

    // -------------------------------------------------------------------------
    // Per-channel detection
    // -------------------------------------------------------------------------
    logic [NumCh-1:0][1:0] secded_err;
    logic [NumCh-1:0]      data_err;
    logic [NumCh-1:0]      chk;
    logic [NumCh-1:0]      ev;
    logic [NumCh-1:0]      unused_bits;

    always_comb begin
        for (int i = 0; i < NumCh; i++) begin
            secded_err[i] = secded_dec(rsp_payload(tl_i[i]), tl_i[i].d_user.rsp_intg);
            if (EnableRspDataIntgCheck) begin
                data_err[i] = |secded_dec({25'b0, tl_i[i].d_data}, tl_i[i].d_user.data_intg);
            end else begin
                data_err[i] = 1'b0;
            end
            chk[i] = tl_i[i].d_valid & ((|secded_err[i]) | data_err[i]);
            ev[i]  = chk[i] & d_ready_i[i];
            // Fields this monitor does not inspect (data fields too, when the
            // data check is disabled).
            unused_bits[i] = tl_i[i].a_ready ^ (^tl_i[i].d_data) ^ (^tl_i[i].d_user.data_intg);
        end
    end

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    logic [NumCh-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [NumCh-1:0]           sticky_q, sticky_d;
    logic                       fvld_q, fvld_d;
    logic [ChW-1:0]             fch_q, fch_d;
    logic [ChW-1:0]             ev_low;
    logic [1:0]                 state_q, state_d;
    logic                       alert_q;
    logic                       any_over;

    // When clear and an event happen in the same cycle, the event is applied
    // on top of the cleared value. The channel ends up with count 1 and its
    // sticky flag set.
    always_comb begin
        any_over = 1'b0;
        for (int i = 0; i < NumCh; i++) begin
            cnt_d[i] = clr_i ? '0 : cnt_q[i];
            if (ev[i] && (cnt_d[i] != CntMax)) begin
                cnt_d[i] = cnt_d[i] + CntW'(1);
            end
            sticky_d[i] = ev[i] | (sticky_q[i] & ~clr_i);
            if (cnt_d[i] >= Thresh) begin
                any_over = 1'b1;
            end
        end
    end

    // Lowest-index event wins the first-error capture.
    always_comb begin
        ev_low = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (ev[i]) begin
                ev_low = ChW'(i);
            end
        end
    end

    // Clear empties the capture, so an event in the clearing cycle reloads it.
    always_comb begin
        fvld_d = fvld_q & ~clr_i;
        fch_d  = clr_i ? '0 : fch_q;
        if (!fvld_d && (|ev)) begin
            fvld_d = 1'b1;
            fch_d  = ev_low;
        end
    end

    // The FSM uses next-cycle counter and sticky values. The alert therefore
    // rises together with the counter that crosses the threshold.
    always_comb begin
        if (any_over) begin
            state_d = StAlert;
        end else if ((state_q == StAlert) && !clr_i) begin
            state_d = StAlert;
        end else if (|sticky_d) begin
            state_d = StErr;
        end else begin
            state_d = StOk;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            sticky_q <= '0;
            fvld_q   <= 1'b0;
            fch_q    <= '0;
            state_q  <= StOk;
            alert_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            fvld_q   <= fvld_d;
            fch_q    <= fch_d;
            state_q  <= state_d;
            alert_q  <= (state_d == StAlert);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign err_o           = chk;
    assign err_sticky_o    = sticky_q;
    assign err_cnt_o       = cnt_q;
    assign first_err_vld_o = fvld_q;
    assign first_err_ch_o  = fch_q;
    assign state_o         = state_q;
    assign alert_o         = alert_q;

    // Parameter sanity: the channel count and threshold must be in range.
    param_check : assert property (@(posedge clk_i)
        (NumCh >= 1) && (NumCh <= 16) && (ErrThresh >= 1) && (ErrThresh < (1 << CntW)));

endmodule

// File: tb/tb_caliptra_tlul_rsp_intg_monitor.sv
// -----------------------------------------------------------------------------
// tb_caliptra_tlul_rsp_intg_monitor
//
// Two monitors share the same stimulus:
//   dut_a: data check on,  CntW=2, ErrThresh=3 (saturation, ERR state)
//   dut_b: data check off, CntW=8, ErrThresh=1 (direct OK->ALERT)
// The driver issues one cycle at a time. It updates a reference model that
// works from per-channel counts and flags, then queues the expected
// observation for each DUT. A monitor pops the queues and compares one
// sample per clock.
// -----------------------------------------------------------------------------
module tb_caliptra_tlul_rsp_intg_monitor;
    import caliptra_tlul_rsp_intg_monitor_pkg::*;

    localparam int NCH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n   = 1'b0;
    logic           clr     = 1'b0;
    logic [NCH-1:0] d_ready = '0;
    tl_d2h_t        tl [NCH];

    logic [NCH-1:0]   err_a, sticky_a, err_b, sticky_b;
    logic [NCH*2-1:0] cnt_a;
    logic [NCH*8-1:0] cnt_b;
    logic             fvld_a, fvld_b, alert_a, alert_b;
    logic [0:0]       fch_a, fch_b;
    logic [1:0]       state_a, state_b;

    caliptra_tlul_rsp_intg_monitor #(
        .NumCh(NCH), .EnableRspDataIntgCheck(1'b1), .CntW(2), .ErrThresh(3)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl), .d_ready_i(d_ready), .clr_i(clr),
        .err_o(err_a), .err_sticky_o(sticky_a), .err_cnt_o(cnt_a),
        .first_err_vld_o(fvld_a), .first_err_ch_o(fch_a), .state_o(state_a),
        .alert_o(alert_a)
    );

    caliptra_tlul_rsp_intg_monitor #(
        .NumCh(NCH), .EnableRspDataIntgCheck(1'b0), .CntW(8), .ErrThresh(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .tl_i(tl), .d_ready_i(d_ready), .clr_i(clr),
        .err_o(err_b), .err_sticky_o(sticky_b), .err_cnt_o(cnt_b),
        .first_err_vld_o(fvld_b), .first_err_ch_o(fch_b), .state_o(state_b),
        .alert_o(alert_b)
    );

    // ---------------- stimulus helpers ----------------
    typedef struct packed {
        tl_d2h_t tl;
        bit      rsp_bad;
        bit      data_bad;
    } beat_t;

    int pos_tab [57];   // code position used by payload bit i

    // Extended Hamming check bits: XOR of the positions of the set bits,
    // plus an even-parity bit over everything.
    function automatic logic [6:0] enc(input logic [56:0] d);
        int         acc;
        logic [5:0] s;
        acc = 0;
        for (int i = 0; i < 57; i++) begin
            if (d[i]) acc = acc ^ pos_tab[i];
        end
        s = 6'(acc);
        return {(^d) ^ (^s), s};
    endfunction

    // kind: 0 clean, 1 header bit flip, 2 rsp_intg flip, 3 data flip,
    //       4 data_intg flip, 5 garbage integrity (only with valid=0)
    function automatic beat_t make_beat(input bit valid, input int kind);
        beat_t       b;
        logic [17:0] hdr;
        logic [31:0] data;
        logic [6:0]  ri, di;
        int          idx;
        hdr  = 18'($urandom);
        data = $urandom;
        ri   = enc({39'b0, hdr});
        di   = enc({25'b0, data});
        b    = '0;
        case (kind)
            1: begin idx = $urandom_range(17, 0); hdr[idx]  = ~hdr[idx];  b.rsp_bad  = 1'b1; end
            2: begin idx = $urandom_range(6, 0);  ri[idx]   = ~ri[idx];   b.rsp_bad  = 1'b1; end
            3: begin idx = $urandom_range(31, 0); data[idx] = ~data[idx]; b.data_bad = 1'b1; end
            4: begin idx = $urandom_range(6, 0);  di[idx]   = ~di[idx];   b.data_bad = 1'b1; end
            5: begin ri = 7'($urandom); di = 7'($urandom); end
            default: ;
        endcase
        b.tl.d_valid = valid;
        {b.tl.d_opcode, b.tl.d_param, b.tl.d_size, b.tl.d_source, b.tl.d_sink, b.tl.d_error} = hdr;
        b.tl.d_data             = data;
        b.tl.d_user.rsp_intg    = ri;
        b.tl.d_user.data_intg   = di;
        b.tl.a_ready            = 1'b1;
        return b;
    endfunction

    // ---------------- reference model ----------------
    int cnt_max [2] = '{3, 255};
    int thresh  [2] = '{3, 1};
    bit dchk    [2] = '{1'b1, 1'b0};

    int    cnt_m    [2][NCH];
    bit    sticky_m [2][NCH];
    bit    fvld_m   [2];
    int    fch_m    [2];
    beat_t cur      [NCH];

    // record: {err[1:0], sticky[1:0], cnt1[7:0], cnt0[7:0], fvld, fch, state[1:0], alert}
    logic [24:0] exp_q_a [$];
    logic [24:0] exp_q_b [$];

    task automatic model_step(input int k, input bit [NCH-1:0] rdy, input bit c, input bit r);
        bit [NCH-1:0] err;
        int           first;
        int           st;
        logic [24:0]  rec;
        first = -1;
        for (int i = 0; i < NCH; i++) begin
            err[i] = cur[i].tl.d_valid && (cur[i].rsp_bad || (dchk[k] && cur[i].data_bad));
        end
        if (r || c) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_m[k][i]    = 0;
                sticky_m[k][i] = 1'b0;
            end
            fvld_m[k] = 1'b0;
            fch_m[k]  = 0;
        end
        if (!r) begin
            for (int i = 0; i < NCH; i++) begin
                if (err[i] && rdy[i]) begin
                    if (cnt_m[k][i] < cnt_max[k]) cnt_m[k][i]++;
                    sticky_m[k][i] = 1'b1;
                    if (first < 0) first = i;
                end
            end
            if (!fvld_m[k] && first >= 0) begin
                fvld_m[k] = 1'b1;
                fch_m[k]  = first;
            end
        end
        st = 0;
        for (int i = 0; i < NCH; i++) if (sticky_m[k][i]) st = 1;
        for (int i = 0; i < NCH; i++) if (cnt_m[k][i] >= thresh[k]) st = 2;
        rec = {err, sticky_m[k][1], sticky_m[k][0], 8'(cnt_m[k][1]), 8'(cnt_m[k][0]),
               fvld_m[k], 1'(fch_m[k]), 2'(st), (st == 2)};
        if (k == 0) exp_q_a.push_back(rec);
        else        exp_q_b.push_back(rec);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input beat_t b0, input beat_t b1, input bit [NCH-1:0] rdy,
                         input bit c, input bit r);
        @(negedge clk);
        cur[0]  = b0;
        cur[1]  = b1;
        tl[0]   = b0.tl;
        tl[1]   = b1.tl;
        d_ready = rdy;
        clr     = c;
        rst_n   = ~r;
        model_step(0, rdy, c, r);
        model_step(1, rdy, c, r);
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    logic [24:0] ea, eb;

    always @(posedge clk) begin
        #1;
        if (exp_q_a.size() > 0) begin
            ea = exp_q_a.pop_front();
            check("a.err",    32'(err_a),    32'(ea[24:23]));
            check("a.sticky", 32'(sticky_a), 32'(ea[22:21]));
            check("a.cnt",    {16'b0, 6'b0, cnt_a[3:2], 6'b0, cnt_a[1:0]}, 32'(ea[20:5]));
            check("a.first",  32'({fvld_a, fch_a}), 32'(ea[4:3]));
            check("a.state",  32'(state_a),  32'(ea[2:1]));
            check("a.alert",  32'(alert_a),  32'(ea[0]));
        end
        if (exp_q_b.size() > 0) begin
            eb = exp_q_b.pop_front();
            check("b.err",    32'(err_b),    32'(eb[24:23]));
            check("b.sticky", 32'(sticky_b), 32'(eb[22:21]));
            check("b.cnt",    32'(cnt_b),    32'(eb[20:5]));
            check("b.first",  32'({fvld_b, fch_b}), 32'(eb[4:3]));
            check("b.state",  32'(state_b),  32'(eb[2:1]));
            check("b.alert",  32'(alert_b),  32'(eb[0]));
        end
    end

    // ---------------- test sequence ----------------
    beat_t idle, bad;

    initial begin
        int p;
        p = 1;
        for (int i = 0; i < 57; i++) begin
            while ((p & (p - 1)) == 0) p++;
            pos_tab[i] = p;
            p++;
        end
        idle  = make_beat(1'b0, 0);
        tl[0] = idle.tl;
        tl[1] = idle.tl;

        // reset
        repeat (3) drive(idle, idle, 2'b00, 1'b0, 1'b1);

        // clean traffic on both channels
        repeat (20) drive(make_beat(1'b1, 0), make_beat(1'b1, 0), 2'b11, 1'b0, 1'b0);

        // ch1 bad beat stalled three cycles, then accepted once
        bad = make_beat(1'b1, 2);
        repeat (3) drive(idle, bad, 2'b00, 1'b0, 1'b0);
        drive(idle, bad, 2'b10, 1'b0, 1'b0);
        repeat (2) drive(idle, idle, 2'b11, 1'b0, 1'b0);

        // clear, then simultaneous errors on both channels, then two more on ch0
        drive(idle, idle, 2'b00, 1'b1, 1'b0);
        drive(make_beat(1'b1, 1), make_beat(1'b1, 2), 2'b11, 1'b0, 1'b0);
        repeat (2) drive(make_beat(1'b1, 2), idle, 2'b11, 1'b0, 1'b0);
        repeat (2) drive(idle, idle, 2'b11, 1'b0, 1'b0);

        // saturation: six accepted rsp errors on ch0
        drive(idle, idle, 2'b00, 1'b1, 1'b0);
        repeat (6) drive(make_beat(1'b1, $urandom_range(2, 1)), idle, 2'b01, 1'b0, 1'b0);
        drive(idle, idle, 2'b11, 1'b0, 1'b0);

        // clear alone, then clear together with a ch1 error
        drive(idle, idle, 2'b00, 1'b1, 1'b0);
        drive(idle, idle, 2'b00, 1'b0, 1'b0);
        drive(idle, make_beat(1'b1, 1), 2'b10, 1'b1, 1'b0);
        repeat (2) drive(idle, idle, 2'b11, 1'b0, 1'b0);

        // data-only corruption: seen only by the data-checking instance
        drive(idle, idle, 2'b00, 1'b1, 1'b0);
        drive(make_beat(1'b1, 3), idle, 2'b01, 1'b0, 1'b0);
        drive(idle, make_beat(1'b1, 4), 2'b10, 1'b0, 1'b0);
        drive(idle, idle, 2'b11, 1'b0, 1'b0);

        // reach ALERT, then a one-cycle reset
        repeat (3) drive(make_beat(1'b1, 2), idle, 2'b01, 1'b0, 1'b0);
        drive(idle, idle, 2'b11, 1'b0, 1'b0);
        drive(idle, idle, 2'b00, 1'b0, 1'b1);
        repeat (2) drive(idle, idle, 2'b11, 1'b0, 1'b0);

        // invalid beats with garbage integrity are ignored
        repeat (5) drive(make_beat(1'b0, 5), make_beat(1'b0, 5), 2'b11, 1'b0, 1'b0);

        // randomized traffic
        repeat (500) begin
            beat_t b [NCH];
            for (int i = 0; i < NCH; i++) begin
                bit v;
                int kk;
                v  = ($urandom_range(3, 0) != 0);
                kk = $urandom_range(9, 0);
                kk = (kk < 5) ? 0 : kk - 5;
                if (!v && $urandom_range(1, 0) == 1) kk = 5;
                b[i] = make_beat(v, kk);
            end
            drive(b[0], b[1], 2'($urandom), ($urandom_range(24, 0) == 0),
                  ($urandom_range(149, 0) == 0));
        end

        // drain
        drive(idle, idle, 2'b00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("a.drain", 32'(exp_q_a.size()), 32'd0);
        check("b.drain", 32'(exp_q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
